// File: rtl/ysyx_22041211_ifu.sv
//============================================================================
// Module      : ysyx_22041211_ifu
// Description : Instruction fetch unit. Holds the architectural PC, issues
//               single-beat reads over an AXI4-Lite-style AR/R channel and
//               hands each fetched instruction to decode with valid/ready.
//               Sequential PC+4 fetch, one outstanding read, with a redirect
//               input from execute/branch logic.
// Ports       : clk, rst_n            - clock, async active-low reset
//               araddr_o/arvalid_o/arready_i         - read address channel
//               rdata_i/rresp_i/rvalid_i/rready_o    - read data channel
//               inst_o/pc_o/inst_err_o/inst_valid_o/inst_ready_i - to decode
//               redirect_valid_i/redirect_pc_i       - fetch redirect
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ysyx_22041211_ifu #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,   // instruction width, must be 32
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    // AR channel
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    // R channel
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    // decode interface
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_err_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    // redirect
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] pc_q;
    // Set when the read in flight belongs to a PC that was redirected away
    // from; its data must be thrown away and the new PC fetched instead.
    logic              drop_q;

    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] pc_next_seq;

    assign redir_pc    = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign pc_next_seq = pc_q + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            araddr_o     <= '0;
            arvalid_o    <= 1'b0;
            rready_o     <= 1'b0;
            inst_o       <= '0;
            pc_o         <= '0;
            inst_err_o   <= 1'b0;
            inst_valid_o <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    arvalid_o <= 1'b1;
                    state_q   <= S_AR;
                    if (redirect_valid_i) begin
                        pc_q     <= redir_pc;
                        araddr_o <= redir_pc;
                    end else begin
                        araddr_o <= pc_q;
                    end
                end

                S_AR: begin
                    // The address already on the bus is never retracted; a
                    // redirect here only marks the pending read as stale.
                    if (redirect_valid_i) begin
                        pc_q   <= redir_pc;
                        drop_q <= 1'b1;
                    end
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state_q   <= S_R;
                    end
                end

                S_R: begin
                    if (rvalid_i) begin
                        rready_o <= 1'b0;
                        if (redirect_valid_i || drop_q) begin
                            // Stale data: discard and refetch the current target.
                            drop_q    <= 1'b0;
                            arvalid_o <= 1'b1;
                            state_q   <= S_AR;
                            if (redirect_valid_i) begin
                                pc_q     <= redir_pc;
                                araddr_o <= redir_pc;
                            end else begin
                                araddr_o <= pc_q;
                            end
                        end else begin
                            inst_o       <= rdata_i;
                            pc_o         <= pc_q;
                            inst_err_o   <= (rresp_i != 2'b00);
                            inst_valid_o <= 1'b1;
                            state_q      <= S_OUT;
                        end
                    end else if (redirect_valid_i) begin
                        pc_q   <= redir_pc;
                        drop_q <= 1'b1;
                    end
                end

                S_OUT: begin
                    if (redirect_valid_i) begin
                        // Kill the presented instruction even if decode takes it.
                        inst_valid_o <= 1'b0;
                        pc_q         <= redir_pc;
                        arvalid_o    <= 1'b1;
                        araddr_o     <= redir_pc;
                        state_q      <= S_AR;
                    end else if (inst_valid_o && inst_ready_i) begin
                        inst_valid_o <= 1'b0;
                        pc_q         <= pc_next_seq;
                        arvalid_o    <= 1'b1;
                        araddr_o     <= pc_next_seq;
                        state_q      <= S_AR;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041211_ifu.sv
`default_nettype none

module tb_ysyx_22041211_ifu;

    logic        clk;
    logic        rst_n;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_err_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22041211_ifu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .araddr_o         (araddr_o),
        .arvalid_o        (arvalid_o),
        .arready_i        (arready_i),
        .rdata_i          (rdata_i),
        .rresp_i          (rresp_i),
        .rvalid_i         (rvalid_i),
        .rready_o         (rready_o),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .inst_err_o       (inst_err_o),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          ar_dly;
        int          r_dly;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          stall;
        logic [31:0] addr;
        logic        err;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge and
    // inputs changed at the same point take effect on the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch: AR handshake after ar_dly wait cycles, R handshake
    // after r_dly wait cycles, decode stalls for 'stall' cycles then accepts.
    task automatic fetch_one(input vec_t v);
        int waited = 0;
        while (!arvalid_o && waited < 20) begin
            tick();
            waited++;
        end
        check("ar_issue", {31'd0, arvalid_o}, 32'd1);
        check("araddr", araddr_o, v.addr);
        for (int i = 0; i < v.ar_dly; i++) begin
            tick();
            check("araddr_stable", araddr_o, v.addr);
            check("arvalid_held", {31'd0, arvalid_o}, 32'd1);
        end
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check("ar_done_arvalid", {31'd0, arvalid_o}, 32'd0);
        check("rready_up", {31'd0, rready_o}, 32'd1);
        for (int i = 0; i < v.r_dly; i++) begin
            tick();
            check("rready_wait", {31'd0, rready_o}, 32'd1);
            check("no_early_valid", {31'd0, inst_valid_o}, 32'd0);
        end
        rvalid_i = 1'b1;
        rdata_i  = v.rdata;
        rresp_i  = v.rresp;
        tick();
        rvalid_i = 1'b0;
        rresp_i  = 2'b00;
        check("inst_valid", {31'd0, inst_valid_o}, 32'd1);
        check("inst", inst_o, v.rdata);
        check("pc", pc_o, v.addr);
        check("inst_err", {31'd0, inst_err_o}, {31'd0, v.err});
        check("rready_down", {31'd0, rready_o}, 32'd0);
        for (int i = 0; i < v.stall; i++) begin
            tick();
            check("stall_inst", inst_o, v.rdata);
            check("stall_pc", pc_o, v.addr);
            check("stall_no_ar", {31'd0, arvalid_o}, 32'd0);
        end
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        check("accept_valid_low", {31'd0, inst_valid_o}, 32'd0);
        check("next_arvalid", {31'd0, arvalid_o}, 32'd1);
        check("next_araddr", araddr_o, v.addr + 32'd4);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = target;
    endtask

    task automatic clear_redirect();
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
    endtask

    vec_t v;

    initial begin
        rst_n            = 1'b0;
        arready_i        = 1'b0;
        rdata_i          = '0;
        rresp_i          = 2'b00;
        rvalid_i         = 1'b0;
        inst_ready_i     = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;

        //           ar r  rdata         resp   stall addr           err
        vecs[0] = '{0, 0, 32'h00000413, 2'b00, 0, 32'h8000_0000, 1'b0};
        vecs[1] = '{0, 0, 32'h00100093, 2'b00, 5, 32'h8000_0004, 1'b0};
        vecs[2] = '{0, 0, 32'hdeadbeef, 2'b10, 1, 32'h8000_0008, 1'b1};
        vecs[3] = '{3, 4, 32'h00208113, 2'b00, 0, 32'h8000_000C, 1'b0};

        tick();
        tick();
        check("rst_arvalid", {31'd0, arvalid_o}, 32'd0);
        check("rst_araddr", araddr_o, 32'd0);
        check("rst_rready", {31'd0, rready_o}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);

        rst_n = 1'b1;
        tick();
        // IDLE lasts one cycle, so the first address is already presented.
        check("first_arvalid", {31'd0, arvalid_o}, 32'd1);
        check("first_araddr", araddr_o, 32'h8000_0000);

        for (int i = 0; i < 4; i++) begin
            fetch_one(vecs[i]);
        end

        // Redirect while in R with rvalid low: returned data is discarded.
        check("seqA_araddr", araddr_o, 32'h8000_0010);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        do_redirect(32'h8000_0103);
        tick();
        clear_redirect();
        check("seqA_still_r", {31'd0, rready_o}, 32'd1);
        rvalid_i = 1'b1;
        rdata_i  = 32'h1111_1111;
        tick();
        rvalid_i = 1'b0;
        check("seqA_dropped", {31'd0, inst_valid_o}, 32'd0);
        check("seqA_refetch_arvalid", {31'd0, arvalid_o}, 32'd1);
        check("seqA_refetch_addr", araddr_o, 32'h8000_0100);
        v = '{0, 0, 32'h2222_2222, 2'b00, 0, 32'h8000_0100, 1'b0};
        fetch_one(v);

        // Redirect in OUT with decode ready the same cycle: instruction killed.
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = 32'h3333_3333;
        tick();
        rvalid_i = 1'b0;
        check("seqB_valid", {31'd0, inst_valid_o}, 32'd1);
        check("seqB_pc", pc_o, 32'h8000_0104);
        inst_ready_i = 1'b1;
        do_redirect(32'h8000_0200);
        tick();
        inst_ready_i = 1'b0;
        clear_redirect();
        check("seqB_killed", {31'd0, inst_valid_o}, 32'd0);
        check("seqB_araddr", araddr_o, 32'h8000_0200);
        v = '{1, 1, 32'h4444_4444, 2'b00, 0, 32'h8000_0200, 1'b0};
        fetch_one(v);

        // Asynchronous reset while in R.
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check("seqC_in_r", {31'd0, rready_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("seqC_rready", {31'd0, rready_o}, 32'd0);
        check("seqC_arvalid", {31'd0, arvalid_o}, 32'd0);
        check("seqC_araddr", araddr_o, 32'd0);
        check("seqC_pc", pc_o, 32'd0);
        check("seqC_inst", inst_o, 32'd0);
        #2;
        rst_n = 1'b1;
        v = '{0, 0, 32'h5555_5555, 2'b00, 0, 32'h8000_0000, 1'b0};
        fetch_one(v);

        // Redirect in AR without arready: address held, pending read dropped.
        do_redirect(32'h8000_0301);
        tick();
        clear_redirect();
        check("seqD_addr_stable", araddr_o, 32'h8000_0004);
        check("seqD_arvalid", {31'd0, arvalid_o}, 32'd1);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = 32'h6666_6666;
        tick();
        rvalid_i = 1'b0;
        check("seqD_dropped", {31'd0, inst_valid_o}, 32'd0);
        check("seqD_refetch_addr", araddr_o, 32'h8000_0300);
        v = '{0, 0, 32'h7777_7777, 2'b00, 0, 32'h8000_0300, 1'b0};
        fetch_one(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_22041211_ifu.md
Name: ysyx_22041211_ifu

Overview:
- Instruction fetch unit: the producer side of the decoder's `inst_i`/`pc_i` interface.
- Holds the architectural PC and issues single-beat instruction reads over an AXI4-Lite-style read channel (AR/R).
- Presents each fetched instruction and its PC to decode with a valid/ready handshake.
- Accepts a redirect from the execute/branch logic, which carries the branch target address.
- One outstanding read at a time; no prediction, sequential PC+4 otherwise.

Parameters:
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
- ADDR_W, 32, address and PC width.
- DATA_W, 32, instruction width; must be 32.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- araddr_o  out  ADDR_W  read address.
- arvalid_o  out  1  read address valid.
- arready_i  in  1  memory accepts address.
- rdata_i  in  DATA_W  read data.
- rresp_i  in  2  read response; 2'b00 OKAY, anything else is an error.
- rvalid_i  in  1  read data valid.
- rready_o  out  1  IFU accepts read data.
- inst_o  out  DATA_W  fetched instruction to decode.
- pc_o  out  ADDR_W  PC of `inst_o`.
- inst_err_o  out  1  fetch faulted (rresp != OKAY); qualified by `inst_valid_o`.
- inst_valid_o  out  1  `inst_o`/`pc_o`/`inst_err_o` valid.
- inst_ready_i  in  1  decode accepts instruction.
- redirect_valid_i  in  1  one-cycle redirect strobe.
- redirect_pc_i  in  ADDR_W  redirect target; bits [1:0] ignored, forced to 0.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, pc_q=RESET_PC, drop_q=0.
  - arvalid_o=0, araddr_o=0, rready_o=0.
  - inst_valid_o=0, inst_o=0, pc_o=0, inst_err_o=0.
  - Reset mid-transaction abandons it; memory-side cleanup is the interconnect's job.
- All outputs are registered.
- States: IDLE, AR, R, OUT.
- IDLE (exactly one cycle after reset release): arvalid_o<=1, araddr_o<=pc_q; go to AR.
- AR: hold arvalid_o=1 and araddr_o stable until arready_i.
  - On arvalid_o & arready_i: arvalid_o<=0, rready_o<=1; go to R.
- R: on rvalid_i & rready_o: rready_o<=0.
  - If drop_q=1: drop_q<=0, arvalid_o<=1, araddr_o<=pc_q; go to AR. The data is discarded and never reaches decode.
  - Else: inst_o<=rdata_i, pc_o<=pc_q, inst_err_o<=(rresp_i!=0), inst_valid_o<=1; go to OUT.
- OUT: hold all decode outputs stable while inst_valid_o & !inst_ready_i.
  - On inst_valid_o & inst_ready_i: inst_valid_o<=0, pc_q<=pc_q+4 (mod 2^32 wrap), arvalid_o<=1, araddr_o<=pc_q+4; go to AR.
- Latency with a zero-wait memory (arready_i=1, rvalid_i=1 in R):
  - AR handshake in cycle t, inst_valid_o=1 in cycle t+2.
  - Peak throughput is 1 instruction / 3 cycles.
- Redirect (redirect_valid_i=1) has priority over every other event in the same cycle. New pc_q = {redirect_pc_i[31:2],2'b00}.
  - In IDLE: pc_q updated; the IDLE-to-AR issue uses the new PC.
  - In AR without arready_i: address stays stable (no AR retraction); pc_q updated, drop_q<=1.
  - In AR with arready_i the same cycle: handshake completes, pc_q updated, drop_q<=1, go to R.
  - In R without rvalid_i: pc_q updated, drop_q<=1.
  - In R with rvalid_i the same cycle: data discarded; arvalid_o<=1, araddr_o<=new PC; go to AR. drop_q stays 0.
  - In OUT: inst_valid_o<=0 even if inst_ready_i=1 (the instruction is killed, not consumed); arvalid_o<=1, araddr_o<=new PC; go to AR.
  - A second redirect while drop_q=1 just overwrites pc_q; only the last target is fetched.
- An error response does not stop fetching. PC advances normally after decode accepts the faulting entry.
- rvalid_i outside R, or arready_i outside AR, is ignored.

Test Plan:
- Reset release, zero-wait memory returning 32'h00000413 → araddr_o=32'h8000_0000; inst_valid_o=1 with pc_o=32'h8000_0000, inst_o=32'h00000413 two cycles after the AR handshake.
- Decode stalls: inst_ready_i=0 for 5 cycles → inst_o and pc_o stay stable. After acceptance, next araddr_o=32'h8000_0004; no AR issued during the stall.
- arready_i delayed 3 cycles, rvalid_i delayed 4 → araddr_o constant throughout; exactly one R handshake; the correct instruction is delivered.
- Redirect to 32'h8000_0103 while in R with rvalid_i low → returned data is discarded. Next araddr_o=32'h8000_0100, and decode sees pc_o=32'h8000_0100 only.
- Redirect to 32'h8000_0200 in OUT with inst_ready_i=1 the same cycle → the killed instruction is not counted as accepted; the next fetch is 32'h8000_0200, not PC+4.
- rresp_i=2'b10 on the fetch at 32'h8000_0008 → inst_err_o=1 with pc_o=32'h8000_0008. After acceptance, fetch continues at 32'h8000_000C.
- rst_n pulsed low in R → all outputs return to reset values immediately; refetch starts from 32'h8000_0000.
